tick_core: RTL and testbench

//   Parametrised 4-register, 8-bit-instruction sequencer core, successor to the fixed 8-bit fetch/regfile loop.

---
 rtl/tick_core.sv | 132 +++++++++++++
 tb/tb_tick_core.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/tick_core.sv
// tick_core: 4-register sequencer, instruction issue paced by a free-running prescaler tick.
// Each issue takes IDLE->FETCH->EXEC. result_valid pulses in the cycle after an OUT executes. There is no backpressure.
module tick_core #(
   parameter int DATA_W   = 8,
   parameter int ADDR_W   = 3,
   parameter int TICK_DIV = 10000000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              run,
   input  logic [7:0]        instruction,
   output logic [ADDR_W-1:0] address,
   output logic [DATA_W-1:0] result,
   output logic              result_valid
);

   localparam int               CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_FETCH = 2'd1;
   localparam logic [1:0] S_EXEC  = 2'd2;

   localparam logic [1:0] OP_OUT = 2'b00;
   localparam logic [1:0] OP_ADD = 2'b01;
   localparam logic [1:0] OP_BNZ = 2'b10;

   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              tick;
   logic [1:0]        state_q, state_d;
   logic [7:0]        ir_q, ir_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [DATA_W-1:0] regs_q [4];
   logic [DATA_W-1:0] regs_d [4];
   logic              z_q, z_d;
   logic [DATA_W-1:0] result_q, result_d;
   logic              vld_q, vld_d;

   logic [1:0]        opcode, ra, rb, rl;
   logic [DATA_W-1:0] sum, imm;

   // The prescaler keeps running in every state. A tick that arrives mid-instruction is lost.
   assign tick  = (cnt_q == CNT_LAST);
   assign cnt_d = tick ? '0 : cnt_q + CNT_W'(1);

   assign opcode = ir_q[7:6];
   assign ra     = ir_q[3:2];
   assign rb     = ir_q[1:0];
   assign rl     = ir_q[5:4];
   assign sum    = regs_q[ra] + regs_q[rb];
   assign imm    = DATA_W'($signed(ir_q[3:0]));

   always_comb begin
      state_d  = state_q;
      ir_d     = ir_q;
      pc_d     = pc_q;
      z_d      = z_q;
      result_d = result_q;
      vld_d    = 1'b0;
      for (int i = 0; i < 4; i++) begin
         regs_d[i] = regs_q[i];
      end

      case (state_q)
         S_IDLE: begin
            if (run && tick) begin
               state_d = S_FETCH;
            end
         end
         S_FETCH: begin
            ir_d    = instruction;
            state_d = S_EXEC;
         end
         S_EXEC: begin
            state_d = S_IDLE;
            pc_d    = pc_q + ADDR_W'(1);
            case (opcode)
               OP_OUT: begin
                  result_d = regs_q[rb];
                  vld_d    = 1'b1;
               end
               OP_ADD: begin
                  regs_d[ra] = sum;
                  z_d        = (sum == '0);
               end
               OP_BNZ: begin
                  if (!z_q) begin
                     pc_d = ir_q[ADDR_W-1:0];
                  end
               end
               default: begin
                  regs_d[rl] = imm;
               end
            endcase
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q    <= '0;
         state_q  <= S_IDLE;
         ir_q     <= '0;
         pc_q     <= '0;
         z_q      <= 1'b1;
         result_q <= '0;
         vld_q    <= 1'b0;
         for (int i = 0; i < 4; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         cnt_q    <= cnt_d;
         state_q  <= state_d;
         ir_q     <= ir_d;
         pc_q     <= pc_d;
         z_q      <= z_d;
         result_q <= result_d;
         vld_q    <= vld_d;
         for (int i = 0; i < 4; i++) begin
            regs_q[i] <= regs_d[i];
         end
      end
   end

   assign address      = pc_q;
   assign result       = result_q;
   assign result_valid = vld_q;

endmodule

// File: tb/tb_tick_core.sv
// Bench for tick_core: instruction-level reference model for TICK_DIV=1, and issue-timing arithmetic for TICK_DIV=2/4.
module tb_tick_core;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic       run_a, run_b, run_c;
   logic [7:0] rom_a [8];
   logic [7:0] rom_t [8];
   logic [2:0] addr_a, addr_b, addr_c;
   logic [7:0] res_a, res_b, res_c;
   logic       vld_a, vld_b, vld_c;
   logic [7:0] ins_a, ins_b, ins_c;

   assign ins_a = rom_a[addr_a];
   assign ins_b = rom_t[addr_b];
   assign ins_c = rom_t[addr_c];

   tick_core #(.DATA_W(8), .ADDR_W(3), .TICK_DIV(1)) dut_a (
      .clk(clk), .rst(rst), .run(run_a), .instruction(ins_a),
      .address(addr_a), .result(res_a), .result_valid(vld_a));

   tick_core #(.DATA_W(8), .ADDR_W(3), .TICK_DIV(2)) dut_b (
      .clk(clk), .rst(rst), .run(run_b), .instruction(ins_b),
      .address(addr_b), .result(res_b), .result_valid(vld_b));

   tick_core #(.DATA_W(8), .ADDR_W(3), .TICK_DIV(4)) dut_c (
      .clk(clk), .rst(rst), .run(run_c), .instruction(ins_c),
      .address(addr_c), .result(res_c), .result_valid(vld_c));

   int n_cmp;
   int n_bad;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference machine state, kept as plain integers.
   int m_r [4];
   int m_z;
   int m_pc;
   int m_res;
   int m_out;

   task automatic model_reset();
      for (int i = 0; i < 4; i++) m_r[i] = 0;
      m_z   = 1;
      m_pc  = 0;
      m_res = 0;
      m_out = 0;
   endtask

   task automatic model_step(input logic [7:0] ins);
      int a, b, s, v;
      m_out = 0;
      a = int'(ins[3:2]);
      b = int'(ins[1:0]);
      case (ins[7:6])
         2'b00: begin
            m_res = m_r[b];
            m_out = 1;
            m_pc  = (m_pc + 1) % 8;
         end
         2'b01: begin
            s       = (m_r[a] + m_r[b]) % 256;
            m_r[a]  = s;
            m_z     = (s == 0) ? 1 : 0;
            m_pc    = (m_pc + 1) % 8;
         end
         2'b10: begin
            if (m_z == 0) m_pc = int'(ins[2:0]);
            else          m_pc = (m_pc + 1) % 8;
         end
         default: begin
            v = int'(ins[3:0]);
            if (v >= 8) v = v - 16;
            m_r[int'(ins[5:4])] = (v + 256) % 256;
            m_pc = (m_pc + 1) % 8;
         end
      endcase
   endtask

   // With TICK_DIV=1 and run held high, instruction k completes on edge 3k after reset release.
   task automatic run_a_instrs(input int n, input string tag);
      logic [7:0] ins;
      for (int k = 0; k < n; k++) begin
         for (int e = 0; e < 2; e++) begin
            @(posedge clk); #1;
            check_eq({tag, "_vld_quiet"}, 32'(vld_a), 32'd0);
         end
         ins = rom_a[m_pc];
         model_step(ins);
         @(posedge clk); #1;
         check_eq({tag, "_pc"},  32'(addr_a), 32'(m_pc));
         check_eq({tag, "_vld"}, 32'(vld_a),  32'(m_out));
         check_eq({tag, "_res"}, 32'(res_a),  32'(m_res));
      end
   endtask

   task automatic do_reset(input string tag);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check_eq({tag, "_rst_addr"}, 32'(addr_a), 32'd0);
      check_eq({tag, "_rst_res"},  32'(res_a),  32'd0);
      check_eq({tag, "_rst_vld"},  32'(vld_a),  32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
   endtask

   initial begin
      int done_b, done_c, pc_b, pc_c;
      n_cmp = 0;
      n_bad = 0;
      rst   = 1'b1;
      run_a = 1'b1;
      run_b = 1'b0;
      run_c = 1'b0;
      foreach (rom_t[i]) rom_t[i] = 8'hC1;
      rom_a = '{8'hF3, 8'h03, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0};
      model_reset();
      repeat (2) @(posedge clk); #1;
      check_eq("init_addr_a", 32'(addr_a), 32'd0);
      check_eq("init_res_a",  32'(res_a),  32'd0);
      check_eq("init_vld_a",  32'(vld_a),  32'd0);
      check_eq("init_addr_c", 32'(addr_c), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // LDI R3,3 then OUT R3
      run_a_instrs(3, "t1");
      check_eq("t1_res_const", 32'(res_a), 32'h03);

      rom_a = '{8'hEF, 8'h02, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0};
      do_reset("t2");
      run_a_instrs(2, "t2");
      check_eq("t2_res_const", 32'(res_a), 32'hFF);

      // Count-down loop: ADD runs three times before BNZ falls through to OUT.
      rom_a = '{8'hC3, 8'hDF, 8'h41, 8'h82, 8'h00, 8'hC0, 8'hC0, 8'hC0};
      do_reset("t3");
      run_a_instrs(9, "t3");
      check_eq("t3_res_const",  32'(res_a),  32'h00);
      check_eq("t3_addr_const", 32'(addr_a), 32'd5);

      foreach (rom_a[i]) rom_a[i] = 8'hC1;
      do_reset("t4");
      run_a_instrs(9, "t4");
      check_eq("t4_wrap_addr", 32'(addr_a), 32'd1);

      // Reset lands during EXEC of instruction 5 (ADD R0+=R1, R0=3, R1=-1).
      rom_a = '{8'h00, 8'hC3, 8'hDF, 8'h00, 8'h41, 8'h00, 8'hC0, 8'hC0};
      do_reset("t6");
      run_a_instrs(4, "t6");
      check_eq("t6_res_before", 32'(res_a), 32'h03);
      repeat (2) begin
         @(posedge clk); #1;
      end
      rst = 1'b1;
      #1;
      check_eq("t6_abort_addr", 32'(addr_a), 32'd0);
      check_eq("t6_abort_res",  32'(res_a),  32'd0);
      check_eq("t6_abort_vld",  32'(vld_a),  32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      run_a_instrs(1, "t6_after");
      check_eq("t6_out_r0", 32'(res_a), 32'h00);
      run_a_instrs(5, "t6_rerun");

      for (int p = 0; p < 4; p++) begin
         foreach (rom_a[i]) rom_a[i] = 8'($urandom_range(0, 255));
         do_reset("rnd");
         run_a_instrs(24, "rnd");
      end

      // Prescaler pacing: a tick is visible in the cycle after edge n when n mod TICK_DIV == TICK_DIV-1.
      @(negedge clk);
      rst   = 1'b1;
      run_b = 1'b1;
      run_c = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst    = 1'b0;
      done_b = 0;
      done_c = 0;
      pc_b   = 0;
      pc_c   = 0;
      for (int n = 0; n < 40; n++) begin
         if (n == 12) run_c = 1'b0;
         if (n >= done_b && (n % 2) == 1 && run_b) done_b = n + 3;
         if (n >= done_c && (n % 4) == 3 && run_c) done_c = n + 3;
         @(posedge clk); #1;
         if (n + 1 == done_b) pc_b = (pc_b + 1) % 8;
         if (n + 1 == done_c) pc_c = (pc_c + 1) % 8;
         check_eq("t5_pc_div2", 32'(addr_b), 32'(pc_b));
         check_eq("t5_pc_div4", 32'(addr_c), 32'(pc_c));
         check_eq("t5_vld",     32'({vld_b, vld_c}), 32'd0);
      end
      check_eq("t5_frozen_div4", 32'(addr_c), 32'd3);
      check_eq("t5_div2_count",  32'(addr_b), 32'd2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
